// File: rtl/turfio_cout_gen_if.sv
// Handshake bundle for the TURFIO cout command generator:
// trigger stream, run command and message channels.
interface turfio_cout_gen_if;
    logic [12:0] trig_addr_i;
    logic        trig_valid_i;
    logic        trig_ready_o;
    logic [1:0]  runcmd_i;
    logic        runcmd_valid_i;
    logic        runcmd_ready_o;
    logic [14:0] msg_i;
    logic        msg_valid_i;
    logic        msg_ready_o;

    modport master (
        output trig_addr_i, trig_valid_i,
        output runcmd_i, runcmd_valid_i,
        output msg_i, msg_valid_i,
        input  trig_ready_o, runcmd_ready_o, msg_ready_o
    );

    modport slave (
        input  trig_addr_i, trig_valid_i,
        input  runcmd_i, runcmd_valid_i,
        input  msg_i, msg_valid_i,
        output trig_ready_o, runcmd_ready_o, msg_ready_o
    );
endinterface

// File: rtl/turfio_cout_gen.sv
// Builds the 32-bit cout command word once per 8-clock frame.
// Define TURFIO_COUT_STATS_EN to add trigger sent/dropped counters.
module turfio_cout_gen #(
    parameter logic [31:0] TRAIN_VALUE = 32'hA55A6996,
    parameter int          FIFO_DEPTH  = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        sysclk_phase_i,
    input  logic        train_i,
    turfio_cout_gen_if.slave bus,
    output logic [31:0] cout_command_o,
    output logic        frame_start_o,
    output logic        phase_err_o
`ifdef TURFIO_COUT_STATS_EN
    ,
    output logic [15:0] trig_sent_count_o,
    output logic [15:0] trig_dropped_o
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {S_TRAIN, S_RUN} state_t;
    state_t r_state, w_state_nxt;

    logic [12:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [CW-1:0] r_count, w_count_nxt;
    logic          r_full, r_empty;

    logic        r_rc_held, r_msg_held;
    logic [1:0]  r_rc;
    logic [14:0] r_msg;
    logic [31:0] r_cout;
    logic        r_fs;
    logic [2:0]  r_pcnt;
    logic        r_seen, r_err;

    logic        w_run, w_bnd, w_load_run;
    logic        w_trig_ready, w_rc_ready, w_msg_ready;
    logic        w_push, w_pop, w_rc_load, w_msg_load;
    logic [31:0] w_word;

    assign w_run      = (r_state == S_RUN);
    assign w_bnd      = sysclk_phase_i;
    assign w_load_run = w_bnd && !train_i;

    assign w_trig_ready = w_run && !r_full;
    assign w_rc_ready   = w_run && !r_rc_held;
    assign w_msg_ready  = w_run && !r_msg_held;

    assign w_push     = bus.trig_valid_i && w_trig_ready;
    // Pop decision uses the registered empty, so a same-edge push waits a frame
    assign w_pop      = w_load_run && !r_empty;
    assign w_rc_load  = bus.runcmd_valid_i && w_rc_ready;
    assign w_msg_load = bus.msg_valid_i && w_msg_ready;

    assign bus.trig_ready_o   = w_trig_ready;
    assign bus.runcmd_ready_o = w_rc_ready;
    assign bus.msg_ready_o    = w_msg_ready;

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= S_TRAIN;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_bnd) w_state_nxt = train_i ? S_TRAIN : S_RUN;
    end

    always_comb begin
        w_count_nxt = r_count;
        unique case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wptr] <= bus.trig_addr_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CW'(FIFO_DEPTH));
            r_empty <= (w_count_nxt == '0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rc_held  <= 1'b0;
            r_rc       <= '0;
            r_msg_held <= 1'b0;
            r_msg      <= '0;
        end else begin
            if (w_load_run && r_rc_held) begin
                r_rc_held <= 1'b0;
            end else if (w_rc_load) begin
                r_rc_held <= 1'b1;
                r_rc      <= bus.runcmd_i;
            end
            if (w_load_run && r_msg_held) begin
                r_msg_held <= 1'b0;
            end else if (w_msg_load) begin
                r_msg_held <= 1'b1;
                r_msg      <= bus.msg_i;
            end
        end
    end

    assign w_word = {r_rc_held ? r_rc : 2'b00,
                     w_pop,
                     w_pop ? r_mem[r_rptr] : 13'd0,
                     r_msg_held,
                     r_msg_held ? r_msg : 15'd0};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cout <= TRAIN_VALUE;
            r_fs   <= 1'b0;
        end else begin
            if (w_bnd) r_cout <= train_i ? TRAIN_VALUE : w_word;
            r_fs <= w_bnd;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pcnt <= '0;
            r_seen <= 1'b0;
            r_err  <= 1'b0;
        end else if (sysclk_phase_i) begin
            if (r_seen && r_pcnt != 3'd7) r_err <= 1'b1;
            r_pcnt <= '0;
            r_seen <= 1'b1;
        end else begin
            r_pcnt <= r_pcnt + 3'd1;
        end
    end

    assign cout_command_o = r_cout;
    assign frame_start_o  = r_fs;
    assign phase_err_o    = r_err;

`ifdef TURFIO_COUT_STATS_EN
    logic [15:0] r_sent, r_drop;
    logic        w_drop_evt;

    assign w_drop_evt = bus.trig_valid_i && !w_trig_ready && w_run;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sent <= '0;
            r_drop <= '0;
        end else begin
            if (w_pop) r_sent <= r_sent + 16'd1;
            if (w_drop_evt && r_drop != 16'hFFFF) r_drop <= r_drop + 16'd1;
        end
    end

    assign trig_sent_count_o = r_sent;
    assign trig_dropped_o    = r_drop;
`endif
endmodule

// File: tb/tb_turfio_cout_gen.sv
// Randomized bench for turfio_cout_gen against a queue-based frame model.
// Stats counters are checked when TURFIO_COUT_STATS_EN is defined.
module tb_turfio_cout_gen;
    localparam logic [31:0] TV    = 32'hA55A6996;
    localparam int          DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, ph, train;
    logic [31:0] cout;
    logic        fs, perr;
`ifdef TURFIO_COUT_STATS_EN
    logic [15:0] sent, drop;
`endif

    turfio_cout_gen_if bus();

    turfio_cout_gen #(.TRAIN_VALUE(TV), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .sysclk_phase_i(ph),
        .train_i(train),
        .bus(bus),
        .cout_command_o(cout),
        .frame_start_o(fs),
        .phase_err_o(perr)
`ifdef TURFIO_COUT_STATS_EN
        ,
        .trig_sent_count_o(sent),
        .trig_dropped_o(drop)
`endif
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Frame-level reference model
    logic [12:0] m_q[$];
    bit          m_run, m_rc_h, m_msg_h, m_fs, m_err, m_seen;
    logic [1:0]  m_rc;
    logic [14:0] m_msg;
    logic [31:0] m_cout;
    int          m_since;
    logic [15:0] m_sent, m_drop;

    function automatic bit m_tready();
        return m_run && (m_q.size() < DEPTH);
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_run = 0; m_rc_h = 0; m_msg_h = 0;
        m_fs = 0; m_err = 0; m_seen = 0; m_since = 0;
        m_rc = '0; m_msg = '0;
        m_cout = TV; m_sent = '0; m_drop = '0;
    endtask

    task automatic model_edge();
        bit          tr, rr, mr, pop;
        logic [12:0] head;
        if (rst) begin
            model_reset();
            return;
        end
        tr = m_tready();
        rr = m_run && !m_rc_h;
        mr = m_run && !m_msg_h;
        pop = 0;
        head = '0;
        if (bus.trig_valid_i && !tr && m_run && m_drop != 16'hFFFF)
            m_drop++;
        if (ph) begin
            if (train) begin
                m_cout = TV;
                m_run = 0;
            end else begin
                pop = (m_q.size() > 0);
                if (pop) head = m_q.pop_front();
                m_cout = {m_rc_h ? m_rc : 2'b00, pop, head,
                          m_msg_h, m_msg_h ? m_msg : 15'd0};
                m_rc_h = 0;
                m_msg_h = 0;
                m_run = 1;
                if (pop) m_sent++;
            end
        end
        if (bus.trig_valid_i && tr) m_q.push_back(bus.trig_addr_i);
        if (bus.runcmd_valid_i && rr) begin m_rc_h = 1; m_rc = bus.runcmd_i; end
        if (bus.msg_valid_i && mr) begin m_msg_h = 1; m_msg = bus.msg_i; end
        m_fs = ph;
        if (ph) begin
            if (m_seen && (m_since % 8) != 7) m_err = 1;
            m_seen = 1;
            m_since = 0;
        end else begin
            m_since++;
        end
    endtask

    task automatic step_ph(input logic p);
        ph = p;
        @(negedge clk);
        chk("trig_ready", bus.trig_ready_o, m_tready());
        chk("runcmd_ready", bus.runcmd_ready_o, m_run && !m_rc_h);
        chk("msg_ready", bus.msg_ready_o, m_run && !m_msg_h);
        @(posedge clk);
        model_edge();
        #1;
        chk("cout", cout, m_cout);
        chk("frame_start", fs, m_fs);
        chk("phase_err", perr, m_err);
`ifdef TURFIO_COUT_STATS_EN
        chk("sent_count", sent, m_sent);
        chk("dropped", drop, m_drop);
`endif
    endtask

    int pc = 0;

    task automatic step();
        step_ph(pc == 0);
        pc = (pc + 1) % 8;
    endtask

    task automatic step_to_frame();
        bit b;
        int g = 0;
        do begin
            b = (pc == 0);
            step();
            g++;
        end while (!b && g < 20);
    endtask

    task automatic idle_inputs();
        bus.trig_valid_i = 0;
        bus.runcmd_valid_i = 0;
        bus.msg_valid_i = 0;
    endtask

    initial begin
        int k, guard;
        bit acc;
        rst = 1; ph = 0; train = 1;
        bus.trig_addr_i = '0; bus.runcmd_i = '0; bus.msg_i = '0;
        idle_inputs();
        model_reset();

        step_ph(1);
        step_ph(0);
        rst = 0;
        pc = 0;

        // Training frames
        for (int f = 0; f < 3; f++) begin
            step_to_frame();
            chk("train_word", cout, TV);
        end

        // Single trig/runcmd/msg frame
        train = 0;
        step_to_frame();
        chk("run_empty", cout, 32'h0);
        bus.trig_valid_i = 1; bus.trig_addr_i = 13'h0ABC;
        bus.runcmd_valid_i = 1; bus.runcmd_i = 2'b01;
        bus.msg_valid_i = 1; bus.msg_i = 15'h1234;
        step();
        idle_inputs();
        step_to_frame();
        chk("full_word", cout, 32'h6ABC9234);
        step_to_frame();
        chk("after_word", cout, 32'h0);

        // Five back-to-back triggers into a depth-4 FIFO
        k = 1; guard = 0;
        bus.trig_valid_i = 1;
        while (k <= 5 && guard < 100) begin
            bus.trig_addr_i = 13'(k);
            acc = m_tready();
            step();
            if (acc) k++;
            if (acc && k == 5) chk("ready_when_full", bus.trig_ready_o, 0);
            guard++;
        end
        if (guard >= 100) chk("fifo_fill_timeout", 1, 0);
        idle_inputs();
        chk("trig_order_1", cout, 32'h20010000);
        for (int j = 2; j <= 5; j++) begin
            step_to_frame();
            chk("trig_order", cout[29:16], {1'b1, 13'(j)});
        end

        // Push on boundary cycle into empty FIFO
        while (pc != 0) step();
        bus.trig_valid_i = 1; bus.trig_addr_i = 13'h155;
        step();
        idle_inputs();
        chk("bnd_push_flag0", cout[29], 0);
        step_to_frame();
        chk("bnd_push_next", cout[29:16], {1'b1, 13'h155});

        // Random traffic, regular phase
        for (int i = 0; i < 600; i++) begin
            if (pc == 0) train = ($urandom_range(0, 3) == 0);
            bus.trig_valid_i = $urandom_range(0, 1);
            bus.trig_addr_i = 13'($urandom);
            bus.runcmd_valid_i = ($urandom_range(0, 3) == 0);
            bus.runcmd_i = 2'($urandom);
            bus.msg_valid_i = ($urandom_range(0, 3) == 0);
            bus.msg_i = 15'($urandom);
            step();
        end
        idle_inputs();
        chk("no_phase_err", perr, 0);

        // Phase pulse arriving at counter 4
        train = 0;
        step_to_frame();
        for (int i = 0; i < 4; i++) step_ph(0);
        step_ph(1);
        chk("phase_err_set", perr, 1);
        pc = 1;
        for (int i = 0; i < 30; i++) step();
        chk("phase_err_sticky", perr, 1);

        // Random traffic with mid-frame resets and phase jitter
        for (int i = 0; i < 800; i++) begin
            if (pc == 0) train = ($urandom_range(0, 4) == 0);
            bus.trig_valid_i = ($urandom_range(0, 2) != 0);
            bus.trig_addr_i = 13'($urandom);
            bus.runcmd_valid_i = $urandom_range(0, 1);
            bus.runcmd_i = 2'($urandom);
            bus.msg_valid_i = $urandom_range(0, 1);
            bus.msg_i = 15'($urandom);
            rst = ($urandom_range(0, 99) == 0);
            if (pc != 0 && $urandom_range(0, 199) == 0) begin
                step_ph(1);
                pc = 1;
            end else begin
                step();
            end
            if (rst) begin
                chk("rst_cout", cout, TV);
                chk("rst_err", perr, 0);
`ifdef TURFIO_COUT_STATS_EN
                chk("rst_sent", sent, 0);
                chk("rst_drop", drop, 0);
`endif
            end
        end
        rst = 0;
        idle_inputs();
        step_to_frame();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end
endmodule
